regfile_access_ctrl: RTL and testbench

Sequencer and arbiter for the single-port `registers` file. It shares the one address/operation port between two requesters: decode, which needs two source operands per instruction, and writeback, which commits one destination per instruction. Operand reads are serialized into two register-file cycles, and a bounded write-priority policy preserves read-after-write ordering without starving decode. The block sits between the decode/writeback stages and the register file.

---
 rtl/regfile_ctrl_pkg.sv | 20 ++
 rtl/regfile_access_ctrl.sv | 136 +++++++++++++
 tb/tb_regfile_access_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and encodings for the register-file access sequencer.
// The operation encodings match the register file's own read/write encoding.
package regfile_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic READ_REG  = 1'b0;
    localparam logic WRITE_REG = 1'b1;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ1,
        ST_READ2,
        ST_RESP
    } state_e;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Shares the single-port register file between decode (two-operand reads) and
// writeback (one write), with bounded write priority so reads are never starved.
module regfile_access_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int WB_BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        rd_req_valid,
    output logic        rd_req_ready,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rd_rsp_valid,
    input  logic        rd_rsp_ready,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,

    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,

    output logic [31:0] rf_address,
    output logic [31:0] rf_input,
    output logic        rf_operation,
    input  logic [31:0] rf_output
);

    localparam logic [3:0] BURST_MAX = 4'(WB_BURST_MAX);
    localparam int         PAD_W     = 32 - REG_IDX_W;

    state_e                 state_q, state_d;
    logic [3:0]             burst_cnt_q, burst_cnt_d;
    logic [REG_IDX_W-1:0]   wb_addr_q, wb_addr_d;
    logic [31:0]            wb_data_q, wb_data_d;
    logic [REG_IDX_W-1:0]   rs1_q, rs1_d;
    logic [REG_IDX_W-1:0]   rs2_q, rs2_d;
    logic [31:0]            rs1_data_q, rs1_data_d;
    logic [31:0]            rs2_data_q, rs2_data_d;
    logic                   force_rd;

    assign force_rd = (burst_cnt_q == BURST_MAX);
    assign rs1_data = rs1_data_q;
    assign rs2_data = rs2_data_q;

    always_comb begin
        state_d      = state_q;
        burst_cnt_d  = burst_cnt_q;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rs1_data_d   = rs1_data_q;
        rs2_data_d   = rs2_data_q;
        wb_ready     = 1'b0;
        rd_req_ready = 1'b0;
        rd_rsp_valid = 1'b0;
        rf_address   = '0;
        rf_input     = '0;
        rf_operation = READ_REG;

        case (state_q)
            ST_IDLE: begin
                wb_ready     = wb_valid && !(force_rd && rd_req_valid);
                rd_req_ready = !wb_valid || force_rd;
                if (wb_valid && wb_ready) begin
                    wb_addr_d = wb_addr;
                    wb_data_d = wb_data;
                    state_d   = ST_WRITE;
                    if (rd_req_valid && (burst_cnt_q != BURST_MAX)) begin
                        burst_cnt_d = burst_cnt_q + 4'd1;
                    end
                end else if (rd_req_valid && rd_req_ready) begin
                    rs1_d       = rs1_addr;
                    rs2_d       = rs2_addr;
                    state_d     = ST_READ1;
                    burst_cnt_d = '0;
                end
                if (!rd_req_valid) begin
                    burst_cnt_d = '0;
                end
            end
            ST_WRITE: begin
                rf_address   = {{PAD_W{1'b0}}, wb_addr_q};
                rf_input     = wb_data_q;
                // x0 is hardwired zero: the cycle is spent but turned into a read.
                rf_operation = (wb_addr_q == REG_ZERO) ? READ_REG : WRITE_REG;
                state_d      = ST_IDLE;
            end
            ST_READ1: begin
                rf_address = {{PAD_W{1'b0}}, rs1_q};
                rs1_data_d = (rs1_q == REG_ZERO) ? '0 : rf_output;
                state_d    = ST_READ2;
            end
            ST_READ2: begin
                rf_address = {{PAD_W{1'b0}}, rs2_q};
                rs2_data_d = (rs2_q == REG_ZERO) ? '0 : rf_output;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                rd_rsp_valid = 1'b1;
                if (rd_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            burst_cnt_q <= '0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl: table-driven write/read pairs
// with a response scoreboard, plus burst, stall and mid-write reset sequences.
module tb_regfile_access_ctrl;
    import regfile_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_req_valid, rd_req_ready;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rd_rsp_valid, rd_rsp_ready;
    logic [31:0] rs1_data, rs2_data;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] rf_address, rf_input, rf_output;
    logic        rf_operation;

    regfile_access_ctrl #(.WB_BURST_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data),
        .rf_address(rf_address), .rf_input(rf_input),
        .rf_operation(rf_operation), .rf_output(rf_output)
    );

    always #5 clk = ~clk;

    // Register file: combinational read, write on rising edge; preloaded with
    // non-zero junk (including x0) so forced-zero reads are observable.
    logic [31:0] rf_mem [32];
    logic        mem_init = 1'b0;
    assign rf_output = rf_mem[rf_address[4:0]];

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hBAD0_0000 | 32'(i);
            mem_init <= 1'b1;
        end else if (rf_operation == WRITE_REG) begin
            rf_mem[rf_address[4:0]] <= rf_input;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    int          last_rd_cyc = 0;
    logic        rsp_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: pops the scoreboard on each operand-pair handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rf_addr_upper_zero", {5'b0, rf_address[31:5]}, 32'd0);
            if (rf_operation == WRITE_REG)
                chk("x0_never_written", {31'b0, rf_address == 32'd0}, 32'd0);
            if (rd_rsp_valid && !rsp_prev)
                chk("rsp_latency", 32'(cyc - last_rd_cyc), 32'd3);
            if (rd_rsp_valid && rd_rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    chk("rs1_data", rs1_data, exp_q[0][63:32]);
                    chk("rs2_data", rs2_data, exp_q[0][31:0]);
                    exp_q.pop_front();
                end
            end
            rsp_prev <= rd_rsp_valid;
        end else begin
            rsp_prev <= 1'b0;
        end
    end

    task automatic issue(input bit do_wr, input logic [4:0] wa, input logic [31:0] wd,
                         input bit do_rd, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [31:0] e1, input logic [31:0] e2,
                         output int wr_cyc, output int rd_cyc);
        bit wr_pend, rd_pend;
        int n;
        wr_cyc = -1;
        rd_cyc = -1;
        @(posedge clk); #1;
        wr_pend = do_wr;
        rd_pend = do_rd;
        wb_valid = do_wr; wb_addr = wa; wb_data = wd;
        rd_req_valid = do_rd; rs1_addr = r1; rs2_addr = r2;
        n = 0;
        while ((wr_pend || rd_pend) && n < 100) begin
            @(negedge clk);
            if (wr_pend && wb_ready) begin
                wr_pend = 1'b0;
                wr_cyc  = cyc;
            end
            if (rd_pend && rd_req_ready) begin
                rd_pend     = 1'b0;
                rd_cyc      = cyc;
                last_rd_cyc = cyc;
                exp_q.push_back({e1, e2});
            end
            @(posedge clk); #1;
            if (!wr_pend) wb_valid = 1'b0;
            if (!rd_pend) rd_req_valid = 1'b0;
            n++;
        end
        chk("issue_accept_in_time", {31'b0, wr_pend || rd_pend}, 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        logic        same;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int wc, rc, k, wr_after, rd_c, wr_resume_c, n;
        bit rd_done;

        tbl[0] = '{1'b0, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 5'd0,  32'h12345678, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd0,  32'hA5A5A5A5, 32'h0};
        tbl[3] = '{1'b0, 5'd31, 32'h00000001, 5'd31, 5'd7,  32'h00000001, 32'hA5A5A5A5};
        tbl[4] = '{1'b1, 5'd1,  32'hFFFFFFFF, 5'd1,  5'd31, 32'hFFFFFFFF, 32'h00000001};

        rst_n = 1'b0;
        rd_req_valid = 1'b0; rs1_addr = '0; rs2_addr = '0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        rd_rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_rf_operation", {31'b0, rf_operation}, 32'd0);
        chk("reset_rd_rsp_valid", {31'b0, rd_rsp_valid}, 32'd0);
        chk("reset_rs1_data", rs1_data, 32'd0);
        chk("reset_rs2_data", rs2_data, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_rf_address", rf_address, 32'd0);
        chk("idle_rf_input", rf_input, 32'd0);
        chk("idle_rd_req_ready", {31'b0, rd_req_ready}, 32'd1);
        chk("idle_wb_ready", {31'b0, wb_ready}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].same) begin
                issue(1'b1, tbl[i].wa, tbl[i].wd, 1'b1, tbl[i].r1, tbl[i].r2,
                      tbl[i].e1, tbl[i].e2, wc, rc);
                chk("same_cycle_write_first", {31'b0, wc < rc}, 32'd1);
            end else begin
                issue(1'b1, tbl[i].wa, tbl[i].wd, 1'b0, '0, '0, '0, '0, wc, rc);
                issue(1'b0, '0, '0, 1'b1, tbl[i].r1, tbl[i].r2, tbl[i].e1, tbl[i].e2, wc, rc);
            end
            drain();
        end
        chk("x0_storage_untouched", rf_mem[0], 32'hBAD0_0000);

        // Continuous writes with a read pending: bounded burst, then the read.
        @(posedge clk); #1;
        rd_req_valid = 1'b1; rs1_addr = 5'd10; rs2_addr = 5'd13;
        wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'h1000_0000;
        k = 0; wr_after = 0; rd_done = 1'b0; rd_c = 0; wr_resume_c = 0;
        for (int n2 = 0; n2 < 60; n2++) begin
            @(negedge clk);
            if (wb_ready) begin
                if (!rd_done) k++;
                else begin
                    wr_after++;
                    wr_resume_c = cyc;
                end
            end
            if (rd_req_valid && rd_req_ready) begin
                rd_done = 1'b1;
                rd_c = cyc;
                last_rd_cyc = cyc;
                exp_q.push_back({32'h1000_0000, 32'h1000_0003});
            end
            @(posedge clk); #1;
            if (rd_done) rd_req_valid = 1'b0;
            wb_addr = 5'(10 + k);
            wb_data = 32'h1000_0000 + 32'(k);
            if (wr_after > 0) break;
        end
        wb_valid = 1'b0;
        chk("burst_writes_before_read", 32'(k), 32'd4);
        chk("burst_read_accepted", {31'b0, rd_done}, 32'd1);
        chk("burst_writes_resume", 32'(wr_after), 32'd1);
        chk("burst_resume_cycle", 32'(wr_resume_c - rd_c), 32'd4);
        drain();

        // Response stall: operands and valid stay put, writeback is blocked.
        rd_rsp_ready = 1'b0;
        issue(1'b0, '0, '0, 1'b1, 5'd10, 5'd5, 32'h1000_0000, 32'hDEADBEEF, wc, rc);
        n = 0;
        while (!rd_rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("stall_rsp_reached", {31'b0, rd_rsp_valid}, 32'd1);
        @(posedge clk); #1;
        wb_valid = 1'b1; wb_addr = 5'd21; wb_data = 32'h7777_7777;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("stall_rd_rsp_valid", {31'b0, rd_rsp_valid}, 32'd1);
            chk("stall_rs1_data", rs1_data, 32'h1000_0000);
            chk("stall_rs2_data", rs2_data, 32'hDEADBEEF);
            chk("stall_wb_ready", {31'b0, wb_ready}, 32'd0);
        end
        @(posedge clk); #1;
        wb_valid = 1'b0;
        rd_rsp_ready = 1'b1;
        drain();

        // Reset asserted while a write is on the register-file port.
        @(posedge clk); #1;
        wb_valid = 1'b1; wb_addr = 5'd20; wb_data = 32'h0000_0055;
        @(negedge clk);
        chk("rst_wr_accept", {31'b0, wb_ready}, 32'd1);
        @(posedge clk); #1;
        wb_valid = 1'b0;
        chk("rst_write_active", {31'b0, rf_operation}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_rf_operation", {31'b0, rf_operation}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_no_partial_write", rf_mem[20], 32'hBAD0_0014);
        chk("post_rst_rf_operation", {31'b0, rf_operation}, 32'd0);
        chk("post_rst_rf_address", rf_address, 32'd0);
        chk("post_rst_rf_input", rf_input, 32'd0);
        chk("post_rst_rd_rsp_valid", {31'b0, rd_rsp_valid}, 32'd0);
        chk("post_rst_rs1_data", rs1_data, 32'd0);
        chk("post_rst_rs2_data", rs2_data, 32'd0);
        chk("post_rst_idle", {31'b0, rd_req_ready}, 32'd1);

        issue(1'b0, '0, '0, 1'b1, 5'd20, 5'd10, 32'hBAD0_0014, 32'h1000_0000, wc, rc);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
